// File: rtl/gpr_file.sv
// ---------------------------------------------------------------------------
// gpr_file -- general purpose register file with issue/writeback scoreboard
//
// Purpose:
//   2^GPRS_WIDTH x DATA_WIDTH register file with one write port (writeback)
//   and two combinational read ports (decode). A busy scoreboard keeps one
//   bit per register. A bit is set when an instruction targeting that
//   register issues, and cleared when its writeback commits. A population
//   count of the busy bits is kept alongside. Register 0 is hardwired to
//   zero and is never marked busy.
//
// Optional feature (macro GPR_BYPASS_EN):
//   When defined, a committing write is forwarded to any read port whose
//   index matches the write index in the same cycle. The busy output of
//   that port then reports 0, unless a busy set to the same index also
//   happens in that cycle.
//   When undefined, the read ports return stored data and the raw
//   registered busy bits.
//
// Parameters:
//   DATA_WIDTH  register data width (default 32)
//   GPRS_WIDTH  register index width, 2^GPRS_WIDTH registers (default 5)
//
// Ports:
//   i_sys_clk              clock, all state on rising edge
//   i_sys_rst              synchronous active-high reset
//   i_wbu_gpr_wr_en/id/data  writeback write port
//   i_idu_gpr_rd_id_a/b    read port indices
//   o_gpr_rd_data_a/b      read port data (combinational)
//   i_idu_gpr_busy_set_en/id  mark destination pending at issue
//   o_gpr_rd_busy_a/b      pending-write flag of the indexed registers
//   o_gpr_busy_cnt         number of pending registers
// ---------------------------------------------------------------------------
module gpr_file #(
  parameter int DATA_WIDTH = 32,
  parameter int GPRS_WIDTH = 5
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_wbu_gpr_wr_en,
  input  logic [GPRS_WIDTH-1:0] i_wbu_gpr_wr_id,
  input  logic [DATA_WIDTH-1:0] i_wbu_gpr_wr_data,
  input  logic [GPRS_WIDTH-1:0] i_idu_gpr_rd_id_a,
  input  logic [GPRS_WIDTH-1:0] i_idu_gpr_rd_id_b,
  output logic [DATA_WIDTH-1:0] o_gpr_rd_data_a,
  output logic [DATA_WIDTH-1:0] o_gpr_rd_data_b,
  input  logic                  i_idu_gpr_busy_set_en,
  input  logic [GPRS_WIDTH-1:0] i_idu_gpr_busy_set_id,
  output logic                  o_gpr_rd_busy_a,
  output logic                  o_gpr_rd_busy_b,
  output logic [GPRS_WIDTH:0]   o_gpr_busy_cnt
);

  localparam int NUM_REGS = 1 << GPRS_WIDTH;
  localparam logic [GPRS_WIDTH:0] CNT_ONE = (GPRS_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_reg;
  logic [NUM_REGS-1:0]   busy_next;
  logic [GPRS_WIDTH:0]   busy_cnt_reg;
  logic [GPRS_WIDTH:0]   busy_cnt_next;

  logic wr_commit;
  logic set_commit;
  logic cnt_inc;
  logic cnt_dec;

  // Index 0 is excluded from both writes and busy sets. Reset dominates a
  // concurrent write, so a write during reset is not a commit (this also
  // keeps it from being forwarded).
  assign wr_commit  = i_wbu_gpr_wr_en && (i_wbu_gpr_wr_id != '0) && !i_sys_rst;
  assign set_commit = i_idu_gpr_busy_set_en && (i_idu_gpr_busy_set_id != '0);

  // -------------------------------------------------------------------------
  // Register storage
  // -------------------------------------------------------------------------
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wr_commit) begin
      regs_reg[i_wbu_gpr_wr_id] <= i_wbu_gpr_wr_data;
    end
  end

  // -------------------------------------------------------------------------
  // Busy scoreboard: a set is applied after the clear, so a new issue to the
  // register being written back leaves the bit set.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
    if (gi == 0) begin : g_zero
      assign busy_next[gi] = 1'b0;
    end else begin : g_bit
      localparam logic [GPRS_WIDTH-1:0] IDX = GPRS_WIDTH'(gi);
      logic hit_set;
      logic hit_clr;
      assign hit_set       = set_commit && (i_idu_gpr_busy_set_id == IDX);
      assign hit_clr       = wr_commit && (i_wbu_gpr_wr_id == IDX);
      assign busy_next[gi] = hit_set || (busy_reg[gi] && !hit_clr);
    end
  end

  // The count follows the bit transitions: at most one 0->1 (from the set
  // port) and one 1->0 (from the write port) per cycle. A clear that is
  // overridden by a set to the same id is not a transition.
  assign cnt_inc = set_commit && !busy_reg[i_idu_gpr_busy_set_id];
  assign cnt_dec = wr_commit && busy_reg[i_wbu_gpr_wr_id] &&
                   !(set_commit && (i_idu_gpr_busy_set_id == i_wbu_gpr_wr_id));

  always_comb begin
    busy_cnt_next = busy_cnt_reg;
    if (cnt_inc && !cnt_dec) begin
      busy_cnt_next = busy_cnt_reg + CNT_ONE;
    end else if (cnt_dec && !cnt_inc) begin
      busy_cnt_next = busy_cnt_reg - CNT_ONE;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      busy_reg     <= '0;
      busy_cnt_reg <= '0;
    end else begin
      busy_reg     <= busy_next;
      busy_cnt_reg <= busy_cnt_next;
    end
  end

  assign o_gpr_busy_cnt = busy_cnt_reg;

  // -------------------------------------------------------------------------
  // Read ports
  // -------------------------------------------------------------------------
  always_comb begin
    // Register 0 is forced to zero so it reads 0 even before any reset.
    o_gpr_rd_data_a = (i_idu_gpr_rd_id_a == '0) ? '0 : regs_reg[i_idu_gpr_rd_id_a];
    o_gpr_rd_data_b = (i_idu_gpr_rd_id_b == '0) ? '0 : regs_reg[i_idu_gpr_rd_id_b];
    o_gpr_rd_busy_a = busy_reg[i_idu_gpr_rd_id_a];
    o_gpr_rd_busy_b = busy_reg[i_idu_gpr_rd_id_b];
`ifdef GPR_BYPASS_EN
    if (wr_commit && (i_wbu_gpr_wr_id == i_idu_gpr_rd_id_a)) begin
      o_gpr_rd_data_a = i_wbu_gpr_wr_data;
      o_gpr_rd_busy_a = set_commit && (i_idu_gpr_busy_set_id == i_idu_gpr_rd_id_a);
    end
    if (wr_commit && (i_wbu_gpr_wr_id == i_idu_gpr_rd_id_b)) begin
      o_gpr_rd_data_b = i_wbu_gpr_wr_data;
      o_gpr_rd_busy_b = set_commit && (i_idu_gpr_busy_set_id == i_idu_gpr_rd_id_b);
    end
`endif
  end

endmodule

// File: tb/tb_gpr_file.sv
module tb_gpr_file;

  localparam int DW = 32;
  localparam int GW = 5;
  localparam int NR = 1 << GW;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [GW-1:0] wr_id;
  logic [DW-1:0] wr_data;
  logic [GW-1:0] rd_id_a;
  logic [GW-1:0] rd_id_b;
  logic [DW-1:0] rd_data_a;
  logic [DW-1:0] rd_data_b;
  logic          set_en;
  logic [GW-1:0] set_id;
  logic          busy_a;
  logic          busy_b;
  logic [GW:0]   busy_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: plain arrays of register contents and pending flags.
  logic [DW-1:0] m_regs [NR];
  bit            m_busy [NR];

  gpr_file #(.DATA_WIDTH(DW), .GPRS_WIDTH(GW)) dut (
    .i_sys_clk            (clk),
    .i_sys_rst            (rst),
    .i_wbu_gpr_wr_en      (wr_en),
    .i_wbu_gpr_wr_id      (wr_id),
    .i_wbu_gpr_wr_data    (wr_data),
    .i_idu_gpr_rd_id_a    (rd_id_a),
    .i_idu_gpr_rd_id_b    (rd_id_b),
    .o_gpr_rd_data_a      (rd_data_a),
    .o_gpr_rd_data_b      (rd_data_b),
    .i_idu_gpr_busy_set_en(set_en),
    .i_idu_gpr_busy_set_id(set_id),
    .o_gpr_rd_busy_a      (busy_a),
    .o_gpr_rd_busy_b      (busy_b),
    .o_gpr_busy_cnt       (busy_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- model helpers (expected values only) ----------------
  function automatic bit commits();
    return !rst && wr_en && (wr_id != 0);
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [GW-1:0] id);
`ifdef GPR_BYPASS_EN
    if (commits() && wr_id == id) return wr_data;
`endif
    if (id == 0) return '0;
    return m_regs[id];
  endfunction

  function automatic logic exp_busy(input logic [GW-1:0] id);
`ifdef GPR_BYPASS_EN
    if (commits() && wr_id == id) return set_en && (set_id == id) && (id != 0);
`endif
    return m_busy[id];
  endfunction

  function automatic logic [GW:0] exp_cnt();
    int n = 0;
    for (int i = 0; i < NR; i++) n += int'(m_busy[i]);
    return (GW + 1)'(n);
  endfunction

  task automatic drive(input logic r, input logic we, input logic [GW-1:0] wid,
                       input logic [DW-1:0] wd, input logic [GW-1:0] ra,
                       input logic [GW-1:0] rb, input logic se,
                       input logic [GW-1:0] sid);
    rst = r; wr_en = we; wr_id = wid; wr_data = wd;
    rd_id_a = ra; rd_id_b = rb; set_en = se; set_id = sid;
    #1;
  endtask

  // Advance one clock edge, applying the same edge to the model.
  task automatic tick();
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wr_en && wr_id != 0) begin
        m_regs[wr_id] = wr_data;
        m_busy[wr_id] = 1'b0;
      end
      if (set_en && set_id != 0) m_busy[set_id] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  // ------------------------------ tests ------------------------------
  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, GW'($urandom), GW'($urandom), 0, 0);
      total++;
      if (rd_data_a !== 0 || rd_data_b !== 0 || busy_a !== 0 || busy_b !== 0 || busy_cnt !== 0) begin
        bad++;
        $display("FAIL reset_state ids=%0d/%0d got a=%h b=%h ba=%b bb=%b cnt=%0d exp all 0",
                 rd_id_a, rd_id_b, rd_data_a, rd_data_b, busy_a, busy_b, busy_cnt);
      end
    end
    $display("txn reset done");
  endtask

  task automatic test_write_read();
    drive(0, 1, 5, 32'hDEADBEEF, 1, 2, 0, 0);
    tick();
    drive(0, 0, 0, 0, 5, 0, 0, 0);
    total++;
    if (rd_data_a !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL write_read_a got=%h exp=%h", rd_data_a, 32'hDEADBEEF);
    end
    total++;
    if (rd_data_b !== 0) begin
      bad++;
      $display("FAIL read_zero_b got=%h exp=0", rd_data_b);
    end
    $display("txn write id=5 read a=%h b=%h", rd_data_a, rd_data_b);
  endtask

  task automatic test_write_zero();
    logic [GW:0] cnt_before;
    cnt_before = exp_cnt();
    drive(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (rd_data_a !== 0 || busy_a !== 0) begin
      bad++;
      $display("FAIL write_zero_read got=%h busy=%b exp=0 busy=0", rd_data_a, busy_a);
    end
    total++;
    if (busy_cnt !== cnt_before) begin
      bad++;
      $display("FAIL write_zero_cnt got=%0d exp=%0d", busy_cnt, cnt_before);
    end
    $display("txn write id=0 read 0 -> %h cnt=%0d", rd_data_a, busy_cnt);
  endtask

  task automatic test_bypass();
    logic [DW-1:0] exp_now;
    drive(0, 1, 7, 32'h11111111, 0, 0, 0, 0);
    tick();
    drive(0, 1, 7, 32'h12345678, 7, 0, 0, 0);
`ifdef GPR_BYPASS_EN
    exp_now = 32'h12345678;
`else
    exp_now = 32'h11111111;
`endif
    total++;
    if (rd_data_a !== exp_now) begin
      bad++;
      $display("FAIL bypass_same_cycle got=%h exp=%h", rd_data_a, exp_now);
    end
    tick();
    drive(0, 0, 0, 0, 7, 7, 0, 0);
    total++;
    if (rd_data_a !== 32'h12345678 || rd_data_b !== 32'h12345678) begin
      bad++;
      $display("FAIL bypass_next_cycle got a=%h b=%h exp=%h", rd_data_a, rd_data_b, 32'h12345678);
    end
    $display("txn write id=7 same-cycle=%h next=%h", exp_now, rd_data_a);
  endtask

  task automatic test_busy();
    drive(0, 0, 0, 0, 0, 0, 1, 3);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 4);
    tick();
    drive(0, 0, 0, 0, 3, 4, 0, 0);
    total++;
    if (busy_cnt !== 2 || busy_a !== 1 || busy_b !== 1) begin
      bad++;
      $display("FAIL busy_set got cnt=%0d ba=%b bb=%b exp cnt=2 ba=1 bb=1", busy_cnt, busy_a, busy_b);
    end
    // writeback and new issue to 3 in the same cycle: set wins
    drive(0, 1, 3, 32'h33, 3, 0, 1, 3);
    total++;
    if (busy_a !== 1) begin
      bad++;
      $display("FAIL busy_setclr_same_cycle got=%b exp=1", busy_a);
    end
    tick();
    drive(0, 0, 0, 0, 3, 4, 0, 0);
    total++;
    if (busy_cnt !== 2 || busy_a !== 1) begin
      bad++;
      $display("FAIL busy_set_wins got cnt=%0d ba=%b exp cnt=2 ba=1", busy_cnt, busy_a);
    end
    drive(0, 1, 4, 32'h44, 3, 4, 0, 0);
    tick();
    drive(0, 0, 0, 0, 3, 4, 0, 0);
    total++;
    if (busy_cnt !== 1 || busy_a !== 1 || busy_b !== 0) begin
      bad++;
      $display("FAIL busy_clear got cnt=%0d ba=%b bb=%b exp cnt=1 ba=1 bb=0", busy_cnt, busy_a, busy_b);
    end
    $display("txn busy scenario cnt=%0d", busy_cnt);
  endtask

  task automatic test_fill_reset();
    for (int i = 1; i < NR; i++) begin
      drive(0, 1, GW'(i), DW'(i * 32'h01010101), 0, 0, 1, GW'(i));
      tick();
    end
    drive(0, 0, 0, 0, 1, GW'(NR - 1), 0, 0);
    total++;
    if (busy_cnt !== (GW + 1)'(NR - 1) || busy_a !== 1 || busy_b !== 1) begin
      bad++;
      $display("FAIL busy_full got cnt=%0d ba=%b bb=%b exp cnt=%0d", busy_cnt, busy_a, busy_b, NR - 1);
    end
    // reset with busy bits pending, plus a concurrent write and set
    drive(1, 1, 12, 32'hCAFEF00D, 0, 0, 1, 13);
    tick();
    for (int i = 0; i < NR; i++) begin
      drive(0, 0, 0, 0, GW'(i), GW'(NR - 1 - i), 0, 0);
      total++;
      if (rd_data_a !== 0 || rd_data_b !== 0 || busy_a !== 0 || busy_b !== 0 || busy_cnt !== 0) begin
        bad++;
        $display("FAIL reset_mid id=%0d got a=%h b=%h ba=%b bb=%b cnt=%0d exp all 0",
                 i, rd_data_a, rd_data_b, busy_a, busy_b, busy_cnt);
      end
    end
    $display("txn fill-then-reset checked %0d ids", NR);
  endtask

  task automatic test_reset_write();
    drive(0, 1, 9, 32'h5A5A5A5A, 0, 0, 0, 0);
    tick();
    drive(1, 1, 9, 32'hA5A5A5A5, 0, 0, 1, 9);
    tick();
    drive(0, 0, 0, 0, 9, 9, 0, 0);
    total++;
    if (rd_data_a !== 0 || busy_a !== 0 || busy_cnt !== 0) begin
      bad++;
      $display("FAIL reset_over_write got=%h busy=%b cnt=%0d exp 0", rd_data_a, busy_a, busy_cnt);
    end
    $display("txn reset+write id=9 read=%h", rd_data_a);
  endtask

  task automatic test_random();
    logic          r, we, se;
    logic [GW-1:0] wid, sid, ra, rb;
    for (int n = 0; n < 400; n++) begin
      r   = ($urandom_range(0, 59) == 0);
      we  = ($urandom_range(0, 2) != 0);
      se  = ($urandom_range(0, 1) != 0);
      wid = GW'($urandom);
      sid = ($urandom_range(0, 7) == 0) ? wid : GW'($urandom);
      ra  = ($urandom_range(0, 3) == 0) ? wid : GW'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? sid : GW'($urandom);
      drive(r, we, wid, DW'($urandom), ra, rb, se, sid);
      total++;
      if (rd_data_a !== exp_rd(ra) || rd_data_b !== exp_rd(rb) ||
          busy_a !== exp_busy(ra) || busy_b !== exp_busy(rb) || busy_cnt !== exp_cnt()) begin
        bad++;
        $display("FAIL random n=%0d ra=%0d rb=%0d got a=%h b=%h ba=%b bb=%b cnt=%0d exp a=%h b=%h ba=%b bb=%b cnt=%0d",
                 n, ra, rb, rd_data_a, rd_data_b, busy_a, busy_b, busy_cnt,
                 exp_rd(ra), exp_rd(rb), exp_busy(ra), exp_busy(rb), exp_cnt());
      end
      $display("txn rnd %0d rst=%b wr=%b/%0d set=%b/%0d cnt=%0d", n, r, we, wid, se, sid, busy_cnt);
      tick();
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_write_read();
    test_write_zero();
    test_bypass();
    test_busy();
    test_fill_reset();
    test_reset_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpr_file.md
GPR_FILE -- requirements
Module: gpr_file

Interface
REQ-001 The block SHALL use these compile-time widths from cfg.sv:
- DATA_WIDTH, default 32, register data width.
- GPRS_WIDTH, default 5, register index width; 2^GPRS_WIDTH registers.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- i_sys_clk  in  1  sole clock; all state updates on its rising edge.
- i_sys_rst  in  1  synchronous, active-high reset.
- i_wbu_gpr_wr_en  in  1  writeback write enable.
- i_wbu_gpr_wr_id  in  GPRS_WIDTH  writeback destination index.
- i_wbu_gpr_wr_data  in  DATA_WIDTH  writeback data.
- i_idu_gpr_rd_id_a  in  GPRS_WIDTH  read port A index.
- i_idu_gpr_rd_id_b  in  GPRS_WIDTH  read port B index.
- o_gpr_rd_data_a  out  DATA_WIDTH  read port A data.
- o_gpr_rd_data_b  out  DATA_WIDTH  read port B data.
- i_idu_gpr_busy_set_en  in  1  mark a destination as pending at issue.
- i_idu_gpr_busy_set_id  in  GPRS_WIDTH  pending destination index.
- o_gpr_rd_busy_a  out  1  port A register has a pending write.
- o_gpr_rd_busy_b  out  1  port B register has a pending write.
- o_gpr_busy_cnt  out  GPRS_WIDTH+1  number of registers currently pending.

Function
REQ-003 Register storage SHALL be 2^GPRS_WIDTH x DATA_WIDTH flops, with one write port and two independent read ports.
REQ-004 Writes SHALL commit on the rising edge when i_wbu_gpr_wr_en=1 and i_wbu_gpr_wr_id!=0, with a latency of 1 cycle.
REQ-005 Register 0 SHALL always read 0; writes to index 0 SHALL be discarded; busy bit 0 SHALL never set.
REQ-006 Reads SHALL be combinational from index to data, with zero latency.
REQ-007 The busy scoreboard SHALL hold one bit per register:
- Set by i_idu_gpr_busy_set_en at id!=0.
- Cleared by a committing write (REQ-004) to the same id.
REQ-008 When a set and a clear target the same id in the same cycle, set SHALL win: the bit remains 1 (a new issue after the old writeback).
REQ-009 Setting an already-busy bit or clearing a non-busy bit SHALL leave the bit unchanged.
REQ-010 o_gpr_busy_cnt SHALL equal the population count of the busy bits after every edge:
- +1 on a 0->1 transition.
- -1 on a 1->0 transition.
- Net 0 when both occur on different ids in one cycle.
- Maximum 2^GPRS_WIDTH-1; no wrap possible.
REQ-011 o_gpr_rd_busy_a/b SHALL reflect the registered busy bit for the indexed register, subject to REQ-015.
REQ-012 Wr_en with id=0 SHALL affect neither data nor scoreboard.

Reset
REQ-013 While i_sys_rst=1 at a rising edge, the block SHALL clear all registers, all busy bits and o_gpr_busy_cnt to 0, and reset SHALL override any concurrent write or busy set.
REQ-014 After reset, the outputs SHALL be: o_gpr_rd_data_a/b=0 for any index, o_gpr_rd_busy_a/b=0 and o_gpr_busy_cnt=0, including when reset is applied mid-operation with busy bits pending.

Configuration
REQ-015 Macro GPR_BYPASS_EN SHALL control same-cycle forwarding from the write port to the read ports:
- Defined: when the write port is committing (REQ-004) to id X and rd_id_a or rd_id_b equals X, that port SHALL return i_wbu_gpr_wr_data in the same cycle. Its busy output SHALL be 0 unless a busy set to X occurs in the same cycle.
- Undefined: read ports SHALL return stored data only, and busy outputs SHALL be the raw registered bits; forwarded data appears one cycle later.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- Write id=5 data=0xDEADBEEF, next cycle read A=5 -> 0xDEADBEEF; read B=0 -> 0.
- Write id=0 data=0xFFFFFFFF, then read 0 -> 0; busy_cnt unchanged.
- Same cycle: write id=7 data=0x12345678 with rd_id_a=7 -> with GPR_BYPASS_EN, 0x12345678 that cycle; without it, the old value that cycle and 0x12345678 next cycle.
- Busy: set id 3, then set id 4 -> cnt=2, busy_a(3)=1. Then write id 3 together with set id 3 -> busy stays 1, cnt=2. Then write id 4 -> cnt=1.
- Set all ids 1..31 -> cnt=31. Then reset mid-sequence -> all busy=0, cnt=0, all reads 0.
- Reset asserted together with write id=9 data=0xA5A5A5A5 -> register 9 reads 0 after the edge.
